// File: rtl/ne_load_unload_fsm_pkg.sv
// ne_load_unload_fsm_pkg
// Decoder geometry shared by the load/unload sequencer and the address
// generator, plus the sequencer state encoding and the last-row lane mask.
package ne_load_unload_fsm_pkg;

  localparam int unsigned Z        = 511;
  localparam int unsigned P        = 26;
  localparam int unsigned ROWDEPTH = 20;
  localparam int unsigned P_LAST   = Z - P * (ROWDEPTH - 1);
  localparam int unsigned ROWWIDTH = 5;
  localparam int unsigned QW       = 8;

  localparam logic [ROWWIDTH-1:0] ROW_LAST = ROWWIDTH'(ROWDEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DECODE,
    ST_UNLOAD,
    ST_DRAIN
  } ne_state_e;

  // Lanes 0..P_LAST-1 set; the remaining lanes of the last row are padding.
  function automatic logic [P-1:0] last_row_mask();
    logic [P-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < P_LAST; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [P-1:0] row_lane_mask(input logic [ROWWIDTH-1:0] row);
    return (row == ROW_LAST) ? last_row_mask() : '1;
  endfunction

endpackage

// File: rtl/ne_hd_tagpipe.sv
// ne_hd_tagpipe
// DEPTH-stage {valid, last} delay line that tracks hard-decision reads in
// flight so the output beat lines up with the memory read data.
//   clk, rst        : clock, synchronous active-low reset (clears all tags)
//   push_valid/last : tag entered with every read issue
//   tail_valid/last : tag leaving the pipe, aligned with the read data
//   inflight        : a tag sits in a stage that will still be occupied
//                     after the next edge (tail excluded)
module ne_hd_tagpipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_last,
  output logic tail_valid,
  output logic tail_last,
  output logic inflight
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d    = '0;
    last_d     = '0;
    valid_d[0] = push_valid;
    last_d[0]  = push_last;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  // The tail is left out so the owner can leave its drain state on the same
  // cycle the final beat is presented.
  always_comb begin
    inflight = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      inflight = inflight | valid_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_last  = last_q[DEPTH-1];

endmodule

// File: rtl/ne_load_unload_fsm.sv
// ne_load_unload_fsm
// I/O sequencer for the layered LDPC decoder: loads one codeword as ROWDEPTH
// row-beats into the L memory, pulses start to the address generator, waits
// for SISOready and streams the hard-decision memory out row by row.
//   clk, rst                 : clock, synchronous active-low reset
//   in_valid/in_ready/in_data: input row-beat handshake
//   lmem_*                   : L-memory write port (we combinational)
//   loaden, start            : address-generator control, registered
//   SISOready                : decode complete
//   hd_rd/hd_raddr/hd_rdata  : hard-decision read port, MEMRDLAT latency
//   out_valid/out_data/out_last : output rows, no backpressure
module ne_load_unload_fsm
  import ne_load_unload_fsm_pkg::*;
#(
  parameter int unsigned MEMRDLAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [P*QW-1:0]     in_data,
  output logic                lmem_we,
  output logic [ROWWIDTH-1:0] lmem_waddr,
  output logic [P*QW-1:0]     lmem_wdata,
  output logic [P-1:0]        lmem_wmask,
  output logic                loaden,
  output logic                start,
  input  logic                SISOready,
  output logic                hd_rd,
  output logic [ROWWIDTH-1:0] hd_raddr,
  input  logic [P-1:0]        hd_rdata,
  output logic                out_valid,
  output logic [P-1:0]        out_data,
  output logic                out_last
);

  ne_state_e           state_q, state_d;
  logic [ROWWIDTH-1:0] row_q, row_d;
  logic                in_ready_q, in_ready_d;
  logic                loaden_q, loaden_d;
  logic                start_q, start_d;
  logic                hd_rd_q, hd_rd_d;

  logic accept;
  logic issue_last;
  logic tag_valid;
  logic tag_last;
  logic tag_inflight;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          row_d   = ROWWIDTH'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (row_q == ROW_LAST) state_d = ST_START;
          else                   row_d   = row_q + ROWWIDTH'(1);
        end
      end
      ST_START: state_d = ST_DECODE;
      ST_DECODE: begin
        if (SISOready) begin
          row_d   = '0;
          state_d = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (row_q == ROW_LAST) state_d = ST_DRAIN;
        else                   row_d   = row_q + ROWWIDTH'(1);
      end
      ST_DRAIN: begin
        if (!tag_inflight) begin
          row_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        row_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    loaden_d   = in_ready_d;
    start_d    = (state_d == ST_START);
    hd_rd_d    = (state_d == ST_UNLOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      in_ready_q <= 1'b1;
      loaden_q   <= 1'b1;
      start_q    <= 1'b0;
      hd_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      in_ready_q <= in_ready_d;
      loaden_q   <= loaden_d;
      start_q    <= start_d;
      hd_rd_q    <= hd_rd_d;
    end
  end

  assign issue_last = hd_rd_q & (row_q == ROW_LAST);

  ne_hd_tagpipe #(
    .DEPTH(MEMRDLAT)
  ) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(hd_rd_q),
    .push_last (issue_last),
    .tail_valid(tag_valid),
    .tail_last (tag_last),
    .inflight  (tag_inflight)
  );

  assign in_ready   = in_ready_q;
  assign loaden     = loaden_q;
  assign start      = start_q;
  assign hd_rd      = hd_rd_q;
  assign hd_raddr   = row_q;

  assign lmem_we    = accept;
  assign lmem_waddr = row_q;
  assign lmem_wdata = in_data;
  assign lmem_wmask = row_lane_mask(row_q);

  assign out_valid  = tag_valid;
  assign out_last   = tag_last;
  assign out_data   = !tag_valid ? '0 : (tag_last ? (hd_rdata & last_row_mask()) : hd_rdata);

endmodule

// File: tb/tb_ne_load_unload_fsm.sv
module tb_ne_load_unload_fsm;

  localparam int ROWS       = 20;
  localparam int LANES      = 26;
  localparam int LAST_LANES = 17;
  localparam int W          = LANES * 8;
  localparam logic [25:0] TAIL = 26'((1 << LAST_LANES) - 1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [W-1:0] in_data;
  logic SISOready;

  always #5 clk = ~clk;

  // suffix = read latency of that instance
  logic in_ready_2, lmem_we_2, loaden_2, start_2, hd_rd_2, out_valid_2, out_last_2;
  logic [4:0] lmem_waddr_2, hd_raddr_2;
  logic [W-1:0] lmem_wdata_2;
  logic [25:0] lmem_wmask_2, hd_rdata_2, out_data_2;

  logic in_ready_1, lmem_we_1, loaden_1, start_1, hd_rd_1, out_valid_1, out_last_1;
  logic [4:0] lmem_waddr_1, hd_raddr_1;
  logic [W-1:0] lmem_wdata_1;
  logic [25:0] lmem_wmask_1, hd_rdata_1, out_data_1;

  logic in_ready_4, lmem_we_4, loaden_4, start_4, hd_rd_4, out_valid_4, out_last_4;
  logic [4:0] lmem_waddr_4, hd_raddr_4;
  logic [W-1:0] lmem_wdata_4;
  logic [25:0] lmem_wmask_4, hd_rdata_4, out_data_4;

  ne_load_unload_fsm #(.MEMRDLAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2), .in_data(in_data),
    .lmem_we(lmem_we_2), .lmem_waddr(lmem_waddr_2), .lmem_wdata(lmem_wdata_2),
    .lmem_wmask(lmem_wmask_2), .loaden(loaden_2), .start(start_2), .SISOready(SISOready),
    .hd_rd(hd_rd_2), .hd_raddr(hd_raddr_2), .hd_rdata(hd_rdata_2),
    .out_valid(out_valid_2), .out_data(out_data_2), .out_last(out_last_2));

  ne_load_unload_fsm #(.MEMRDLAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .in_data(in_data),
    .lmem_we(lmem_we_1), .lmem_waddr(lmem_waddr_1), .lmem_wdata(lmem_wdata_1),
    .lmem_wmask(lmem_wmask_1), .loaden(loaden_1), .start(start_1), .SISOready(SISOready),
    .hd_rd(hd_rd_1), .hd_raddr(hd_raddr_1), .hd_rdata(hd_rdata_1),
    .out_valid(out_valid_1), .out_data(out_data_1), .out_last(out_last_1));

  ne_load_unload_fsm #(.MEMRDLAT(4)) dut_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4), .in_data(in_data),
    .lmem_we(lmem_we_4), .lmem_waddr(lmem_waddr_4), .lmem_wdata(lmem_wdata_4),
    .lmem_wmask(lmem_wmask_4), .loaden(loaden_4), .start(start_4), .SISOready(SISOready),
    .hd_rd(hd_rd_4), .hd_raddr(hd_raddr_4), .hd_rdata(hd_rdata_4),
    .out_valid(out_valid_4), .out_data(out_data_4), .out_last(out_last_4));

  // Hard-decision memory: one shared content, a read pipe per instance.
  logic [25:0] hd_mem [0:31];
  logic [25:0] rp_2 [0:3];
  logic [25:0] rp_1 [0:3];
  logic [25:0] rp_4 [0:3];

  always @(posedge clk) begin
    rp_2[0] <= hd_mem[hd_raddr_2];
    rp_1[0] <= hd_mem[hd_raddr_1];
    rp_4[0] <= hd_mem[hd_raddr_4];
    for (int i = 1; i < 4; i++) begin
      rp_2[i] <= rp_2[i-1];
      rp_1[i] <= rp_1[i-1];
      rp_4[i] <= rp_4[i-1];
    end
  end

  assign hd_rdata_1 = rp_1[0];
  assign hd_rdata_2 = rp_2[1];
  assign hd_rdata_4 = rp_4[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [223:0] t;
    t = '0;
    for (int i = 0; i < 7; i++) t = {t[191:0], 32'($urandom)};
    return t[W-1:0];
  endfunction

  function automatic logic [25:0] exp_mask(input int r);
    return (r == ROWS - 1) ? TAIL : 26'h3FFFFFF;
  endfunction

  function automatic logic [25:0] exp_row(input int j);
    return hd_mem[j] & exp_mask(j);
  endfunction

  task automatic fill_mem(input bit ones);
    for (int i = 0; i < 32; i++) hd_mem[i] = ones ? 26'h3FFFFFF : 26'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"}, in_ready_2, 1'b1);
    chk({tag, " loaden"}, loaden_2, 1'b1);
    chk({tag, " start"}, start_2, 1'b0);
    chk({tag, " lmem_we"}, lmem_we_2, 1'b0);
    chk({tag, " hd_rd"}, hd_rd_2, 1'b0);
    chk({tag, " out_valid"}, out_valid_2, 1'b0);
    chk({tag, " out_last"}, out_last_2, 1'b0);
    chk({tag, " out_data"}, out_data_2, 26'h0);
    chk({tag, " out_valid_l1"}, out_valid_1, 1'b0);
    chk({tag, " out_valid_l4"}, out_valid_4, 1'b0);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_idle($sformatf("%s c%0d", tag, i));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    SISOready = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle(tag);
    @(posedge clk); #1;
  endtask

  // mode 0: continuous, 1: every other cycle, 2: random
  task automatic load_cw(input int mode, input int beats, input bit hold_after);
    int acc;
    int cyc;
    bit v;
    acc = 0;
    cyc = 0;
    while (acc < beats && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = rnd_row();
      @(negedge clk);
      chk($sformatf("load in_ready c%0d", cyc), in_ready_2, 1'b1);
      chk($sformatf("load loaden c%0d", cyc), loaden_2, 1'b1);
      chk($sformatf("load start c%0d", cyc), start_2, 1'b0);
      chk($sformatf("load lmem_we c%0d", cyc), lmem_we_2, v);
      if (v) begin
        chk($sformatf("load waddr r%0d", acc), lmem_waddr_2, acc);
        chk($sformatf("load wmask r%0d", acc), lmem_wmask_2, exp_mask(acc));
        chk($sformatf("load wdata r%0d", acc), lmem_wdata_2, in_data);
      end
      @(posedge clk); #1;
      if (v) acc++;
      cyc++;
    end
    in_valid = hold_after;
  endtask

  task automatic start_phase(input bit siso_in_start);
    SISOready = siso_in_start;
    in_data   = rnd_row();
    @(negedge clk);
    chk("start start", start_2, 1'b1);
    chk("start start_l1", start_1, 1'b1);
    chk("start start_l4", start_4, 1'b1);
    chk("start loaden", loaden_2, 1'b0);
    chk("start in_ready", in_ready_2, 1'b0);
    chk("start lmem_we", lmem_we_2, 1'b0);
    chk("start hd_rd", hd_rd_2, 1'b0);
    @(posedge clk); #1;
    SISOready = 1'b0;
  endtask

  task automatic decode_cw(input int cycles);
    for (int i = 0; i <= cycles; i++) begin
      SISOready = (i == cycles);
      @(negedge clk);
      chk($sformatf("dec start c%0d", i), start_2, 1'b0);
      chk($sformatf("dec loaden c%0d", i), loaden_2, 1'b0);
      chk($sformatf("dec in_ready c%0d", i), in_ready_2, 1'b0);
      chk($sformatf("dec lmem_we c%0d", i), lmem_we_2, 1'b0);
      chk($sformatf("dec hd_rd c%0d", i), hd_rd_2, 1'b0);
      chk($sformatf("dec out_valid c%0d", i), out_valid_2, 1'b0);
      @(posedge clk); #1;
    end
    SISOready = 1'b0;
  endtask

  task automatic chk_unl(input string nm, input int k, input int lat, input logic ov,
                         input logic ol, input logic [25:0] od, input logic rdy);
    int j;
    logic ev;
    j  = k - lat;
    ev = (j >= 0) && (j < ROWS);
    chk($sformatf("%s out_valid k%0d", nm, k), ov, ev);
    chk($sformatf("%s out_last k%0d", nm, k), ol, ev && (j == ROWS - 1));
    chk($sformatf("%s out_data k%0d", nm, k), od, ev ? exp_row(j) : 26'h0);
    chk($sformatf("%s in_ready k%0d", nm, k), rdy, k >= ROWS + lat);
  endtask

  // k = 0 is the cycle after the edge that sampled SISOready
  task automatic unload_cw(input int kmax, input int abort_k);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      chk($sformatf("unl hd_rd k%0d", k), hd_rd_2, k < ROWS);
      if (k < ROWS) chk($sformatf("unl hd_raddr k%0d", k), hd_raddr_2, k);
      chk($sformatf("unl start k%0d", k), start_2, 1'b0);
      chk($sformatf("unl loaden k%0d", k), loaden_2, k >= ROWS + 2);
      chk($sformatf("unl lmem_we k%0d", k), lmem_we_2, in_valid && (k >= ROWS + 2));
      if (in_valid && k >= ROWS + 2) chk($sformatf("unl waddr k%0d", k), lmem_waddr_2, 0);
      chk_unl("l2", k, 2, out_valid_2, out_last_2, out_data_2, in_ready_2);
      chk_unl("l1", k, 1, out_valid_1, out_last_1, out_data_1, in_ready_1);
      chk_unl("l4", k, 4, out_valid_4, out_last_4, out_data_4, in_ready_4);
      if (k == abort_k) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    SISOready = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("reset held");
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles("post reset", 3);

    // continuous load, decode about 50 cycles
    load_cw(0, ROWS, 1'b0);
    start_phase(1'b0);
    decode_cw(49);
    unload_cw(25, -1);

    // toggled load, SISOready during START ignored, all-ones memory
    fill_mem(1'b1);
    load_cw(1, ROWS, 1'b0);
    start_phase(1'b1);
    decode_cw($urandom_range(5, 20));
    unload_cw(25, -1);

    // in_valid held high through START/DECODE/UNLOAD
    fill_mem(1'b0);
    load_cw(2, ROWS, 1'b1);
    start_phase(1'b0);
    decode_cw(10);
    unload_cw(22, -1);
    do_reset("rst after hold");

    // reset mid-load at row 7, then a full codeword from row 0
    load_cw(2, 7, 1'b0);
    do_reset("rst mid-load");
    idle_cycles("after rst load", 3);
    fill_mem(1'b0);
    load_cw(2, ROWS, 1'b0);
    start_phase(1'b0);
    decode_cw(8);
    unload_cw(25, -1);

    // reset mid-unload at row 5: no stale beats afterwards
    load_cw(0, ROWS, 1'b0);
    start_phase(1'b0);
    decode_cw(6);
    unload_cw(25, 5);
    @(posedge clk); #1;
    do_reset("rst mid-unload");
    idle_cycles("after rst unload", 8);
    fill_mem(1'b0);
    load_cw(1, ROWS, 1'b0);
    start_phase(1'b0);
    decode_cw(3);
    unload_cw(25, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ne_load_unload_fsm.md
# ne_load_unload_fsm

Input/output sequencer for the layered LDPC decoder. Accepts one codeword of Z LLRs as ROWDEPTH row-beats of P lanes, writes them into the L memory, then releases the decoder address-generator FSM with a one-cycle `start`. It waits for `SISOready` and streams the hard-decision memory out row by row. It sits directly upstream of the address-generator FSM and drives its `loaden` and `start` inputs.

## Interface
- `Z`, 511: codeword length in symbols
- `P`, 26: lanes per row
- `ROWDEPTH`, 20: rows per codeword, ceil(Z/P)
- `P_LAST`, 17: valid lanes in the last row, Z-P*(ROWDEPTH-1)
- `ROWWIDTH`, 5: row address width
- `QW`, 8: LLR width in bits
- `MEMRDLAT`, 2: hard-decision memory read latency in cycles, at least 1

- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous and active-low (one clock; reset is synchronous and active-low)
- `in_valid`  in  1  input row-beat valid
- `in_ready`  out  1  input row-beat accepted when `in_valid & in_ready`
- `in_data`  in  P*QW  one row of LLRs; lane k is bits [k*QW +: QW]
- `lmem_we`  out  1  L-memory write enable
- `lmem_waddr`  out  ROWWIDTH  L-memory row address
- `lmem_wdata`  out  P*QW  equals `in_data`
- `lmem_wmask`  out  P  lane write mask
- `loaden`  out  1  to the address-generator FSM and the L-memory port mux; high means loading
- `start`  out  1  one-cycle decoder start pulse
- `SISOready`  in  1  decoding finished, from the address-generator FSM
- `hd_rd`  out  1  hard-decision memory read enable
- `hd_raddr`  out  ROWWIDTH  hard-decision row address
- `hd_rdata`  in  P  hard-decision row, valid MEMRDLAT cycles after `hd_rd`
- `out_valid`  out  1  output row valid; there is no backpressure, so the sink must accept every beat
- `out_data`  out  P  hard-decision row; lanes at or above P_LAST are forced to 0 on the last row
- `out_last`  out  1  marks the last row of the codeword

## Operation
- States: IDLE, LOAD, START, DECODE, UNLOAD, DRAIN. One row counter `row` (ROWWIDTH bits).
- IDLE
  - `in_ready`=1 and `loaden`=1.
  - An accepted beat writes row 0, sets `row`=1 and moves to LOAD.
- LOAD
  - `in_ready`=1 and `loaden`=1.
  - Each accepted beat writes row `row` and then increments `row`.
  - When `in_valid`=0 the block holds; no write occurs and `row` is unchanged.
  - The beat accepted at `row`=ROWDEPTH-1 moves the FSM to START.
- Write port
  - `lmem_we` = `in_valid & in_ready`, combinational.
  - `lmem_waddr` is the current row.
  - `lmem_wmask` is all ones, except on row ROWDEPTH-1 where it is {(P-P_LAST) zeros, P_LAST ones}.
- START (exactly 1 cycle)
  - `loaden`=0, `start`=1, `in_ready`=0, then DECODE.
  - `loaden` is low in this cycle so the decoder FSM is out of its reset hold when it samples `start`.
- DECODE
  - All outputs idle and `loaden`=0.
  - On `SISOready`=1: `row`=0, then UNLOAD.
  - `SISOready` is ignored in START.
- UNLOAD
  - `hd_rd`=1 with `hd_raddr`=`row`, and `row` increments each cycle.
  - After issuing row ROWDEPTH-1, the FSM moves to DRAIN.
  - Each issue pushes a tag {valid, last} into a MEMRDLAT-deep shift register.
- DRAIN
  - Waits until the tag pipe is empty, then IDLE with `row`=0.
- Output stage
  - `out_valid` and `out_last` come from the tag at the pipe tail.
  - `out_data` = `hd_rdata` masked as for `lmem_wmask` when `out_last`=1.
- `in_valid` is ignored in START/DECODE/UNLOAD/DRAIN, since `in_ready`=0 there. A new codeword cannot overlap an unload.
- Row counter arithmetic is unsigned ROWWIDTH and never exceeds ROWDEPTH-1; there is no wrap.

## Timing
- Reset values, applied while `rst`=0:
  - state IDLE, `row`=0, tag pipe cleared.
  - `in_ready`=1, `loaden`=1, `start`=0, `lmem_we`=0, `hd_rd`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset mid-operation aborts the codeword and returns to IDLE. `loaden`=1 then holds the decoder in its reset.
- `loaden` and `start` are decoded from registered state, so they are glitch-free.
- Last input beat accepted at edge N: `start`=1 in cycle N+1; DECODE from N+2.
- `SISOready` seen at edge M: first `hd_rd` in cycle M+1. Row r appears on `out_valid` MEMRDLAT cycles after its `hd_rd`.
- Output beats are contiguous, ROWDEPTH beats in total.
- IDLE is re-entered on the cycle after the final `out_valid`.
- Minimum codeword turnaround is ROWDEPTH + 1 + decode time + 1 + ROWDEPTH + MEMRDLAT cycles.

## Structure
- Shared package: decoder geometry constants (Z, P, ROWDEPTH, P_LAST, ROWWIDTH, QW), the state encoding, and a last-row lane-mask function shared with the address generator.
- One sub-module: `ne_hd_tagpipe`, the MEMRDLAT-deep {valid, last} delay line.

## Test plan
- Continuous load of 20 beats, `SISOready` raised 50 cycles after `start`:
  - `lmem_waddr` goes 0..19 with `lmem_wmask` = 0x1FFFF on row 19.
  - `start` pulses once with `loaden`=0 in the same cycle.
  - 20 `out_valid` beats follow, `out_last` only on beat 20.
- `in_valid` toggled every other cycle during load:
  - No write while `in_valid`=0.
  - `start` occurs one cycle after the 20th accepted beat.
- `hd_rdata` = 0x3FFFFFF on all rows:
  - `out_data` = 0x3FFFFFF on rows 0..18 and 0x001FFFF on row 19.
- `in_valid` held high during DECODE and UNLOAD:
  - `in_ready`=0 and no `lmem_we`.
  - Loading resumes only after DRAIN returns to IDLE.
- `rst`=0 asserted mid-load (row 7) and again mid-unload (row 5):
  - Outputs return to their reset values next cycle.
  - The following codeword loads from row 0 and produces no stale `out_valid`.
- MEMRDLAT=1 and MEMRDLAT=4: first `out_valid` 1 resp. 4 cycles after the first `hd_rd`; 20 contiguous beats.
